// File: rtl/seg7_reader.sv
// Receive-side 7-segment decoder: filters a multiplexed segment/digit-select bus
// and recovers one hex nibble per digit, with frame and error reporting.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int NDIG          = 4,
  parameter int IDXW          = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              clr,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dig_ok,
  output logic              cap_pulse,
  output logic [IDXW-1:0]   cap_idx,
  output logic              pat_err,
  output logic              sel_err,
  output logic              err_sticky,
  output logic              frame_done
);

  localparam int CW = 8;
  localparam int SW = NDIG + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {TRACK, HOLD} state_t;

  state_t          state;
  logic [SW-1:0]   smp;
  logic [SW-1:0]   smp_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            changed;
  logic            fire;
  logic            sel_onehot;
  logic [IDXW-1:0] sel_idx;
  logic            pat_valid;
  logic [3:0]      pat_nib;
  logic            full;
  logic [NDIG-1:0] ok_set;

  // Returns {valid, nibble}; anything outside the sixteen hex glyphs is invalid.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign smp_nxt = {dig_sel, seg_in};
  assign changed = (smp_nxt != smp);

  always_comb begin
    cnt_nxt = cnt;
    if (changed)
      cnt_nxt = CW'(1);
    else if (cnt < CNT_MAX)
      cnt_nxt = cnt + 1'b1;
  end

  // Capture exactly once per stable window: only from TRACK, on the edge the count saturates.
  assign fire       = (state == TRACK) && (cnt_nxt == CNT_MAX) && (|dig_sel);
  assign sel_onehot = (|dig_sel) && ((dig_sel & (dig_sel - 1'b1)) == '0);
  assign {pat_valid, pat_nib} = decode(seg_in);
  assign full       = &dig_ok;
  assign ok_set     = (fire && sel_onehot) ? dig_sel : '0;

  // NOTE: every output in this block is combinational, so each one gets a default first to avoid latches.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++)
      if (dig_sel[i]) sel_idx = IDXW'(i);
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the digit bank is an ordinary register array with a defined reset value, so it is reset here.
      state      <= TRACK;
      smp        <= '0;
      cnt        <= '0;
      digits     <= '0;
      dig_ok     <= '0;
      cap_pulse  <= 1'b0;
      cap_idx    <= '0;
      pat_err    <= 1'b0;
      sel_err    <= 1'b0;
      err_sticky <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      smp        <= smp_nxt;
      cap_pulse  <= 1'b0;
      pat_err    <= 1'b0;
      sel_err    <= 1'b0;
      frame_done <= 1'b0;
      if (clr) begin
        cnt        <= '0;
        state      <= TRACK;
        dig_ok     <= '0;
        err_sticky <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (fire)
          state <= HOLD;
        else if (changed)
          state <= TRACK;

        // A full bank reports the frame one edge after the completing capture and restarts.
        frame_done <= full;
        dig_ok     <= (full ? '0 : dig_ok) | ok_set;

        if (fire) begin
          if (sel_onehot) begin
            cap_pulse <= 1'b1;
            cap_idx   <= sel_idx;
            if (pat_valid) begin
              for (int i = 0; i < NDIG; i++)
                if (dig_sel[i]) digits[4*i +: 4] <= pat_nib;
            end else begin
              pat_err    <= 1'b1;
              err_sticky <= 1'b1;
            end
          end else begin
            sel_err    <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed plan followed by random windows, checked every
// edge against a run-length reference model.
module tb_seg7_reader;

  localparam int SC = 4;
  localparam int ND = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [6:0]    seg_in;
  logic [ND-1:0] dig_sel;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dig_ok;
  logic          cap_pulse;
  logic [IW-1:0] cap_idx;
  logic          pat_err;
  logic          sel_err;
  logic          err_sticky;
  logic          frame_done;

  seg7_reader #(.STABLE_CYCLES(SC), .NDIG(ND), .IDXW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .clr        (clr),
    .digits     (digits),
    .dig_ok     (dig_ok),
    .cap_pulse  (cap_pulse),
    .cap_idx    (cap_idx),
    .pat_err    (pat_err),
    .sel_err    (sel_err),
    .err_sticky (err_sticky),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: length of the current run of identical samples plus
  // whether this run has already been acted on.
  logic [10:0] m_prev;
  int          m_run;
  bit          m_held;
  logic [15:0] m_digits;
  logic [3:0]  m_ok;
  logic [1:0]  m_idx;
  logic        m_cap, m_pat, m_sel, m_sticky, m_fd;

  int edge_n, n_cap, n_pat, n_sel, n_fd, last_cap_edge, last_fd_edge;

  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_held = 0;
    m_digits = '0; m_ok = '0; m_idx = '0;
    m_cap = 0; m_pat = 0; m_sel = 0; m_sticky = 0; m_fd = 0;
  endtask

  task automatic model_edge(input logic [3:0] sel, input logic [6:0] seg, input logic c);
    logic [10:0] s;
    int k, d;
    s = {sel, seg};
    m_cap = 0; m_pat = 0; m_sel = 0; m_fd = 0;
    if (c) begin
      m_run = 0; m_held = 0; m_ok = '0; m_sticky = 0; m_prev = s;
      return;
    end
    if (s != m_prev) begin
      m_run = 1; m_held = 0;
    end else if (m_run < 1000) begin
      m_run++;
    end
    m_prev = s;
    if (m_ok == 4'hF) begin
      m_fd = 1; m_ok = '0;
    end
    if (!m_held && m_run == SC && sel != 0) begin
      m_held = 1;
      if ($countones(sel) == 1) begin
        k = $clog2(sel);
        m_cap = 1;
        m_idx = 2'(k);
        m_ok[k] = 1'b1;
        d = lookup(seg);
        if (d >= 0) m_digits[4*k +: 4] = 4'(d);
        else        m_pat = 1;
      end else begin
        m_sel = 1;
      end
      m_sticky = m_sticky | m_pat | m_sel;
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".digits"},     32'(digits),     32'(m_digits));
    check({ph, ".dig_ok"},     32'(dig_ok),     32'(m_ok));
    check({ph, ".cap_pulse"},  32'(cap_pulse),  32'(m_cap));
    check({ph, ".cap_idx"},    32'(cap_idx),    32'(m_idx));
    check({ph, ".pat_err"},    32'(pat_err),    32'(m_pat));
    check({ph, ".sel_err"},    32'(sel_err),    32'(m_sel));
    check({ph, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
    check({ph, ".frame_done"}, 32'(frame_done), 32'(m_fd));
  endtask

  task automatic step(input logic [3:0] sel, input logic [6:0] seg, input logic c, input string ph);
    dig_sel = sel; seg_in = seg; clr = c;
    @(posedge clk);
    #1;
    edge_n++;
    model_edge(sel, seg, c);
    compare_all(ph);
    if (cap_pulse)  begin n_cap++; last_cap_edge = edge_n; end
    if (pat_err)    n_pat++;
    if (sel_err)    n_sel++;
    if (frame_done) begin n_fd++; last_fd_edge = edge_n; end
  endtask

  task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n, input string ph);
    for (int i = 0; i < n; i++) step(sel, seg, 1'b0, ph);
  endtask

  task automatic zero_counts();
    n_cap = 0; n_pat = 0; n_sel = 0; n_fd = 0;
  endtask

  initial begin
    logic [3:0] rsel;
    logic [6:0] rseg;
    int a, b, len;
    logic rclr;

    edge_n = 0; last_cap_edge = -1; last_fd_edge = -1;
    zero_counts();
    rst = 1'b1; clr = 1'b0; dig_sel = '0; seg_in = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b0;

    // Single digit held long: exactly one capture after the fourth edge.
    zero_counts();
    hold(4'b0001, 7'h5B, 4, "t1");
    check("t1.cap_at_edge4", 32'(cap_pulse), 32'd1);
    hold(4'b0001, 7'h5B, 6, "t1");
    check("t1.n_cap", 32'(n_cap), 32'd1);
    check("t1.digit0", 32'(digits[3:0]), 32'h2);
    check("t1.dig_ok", 32'(dig_ok), 32'b0001);
    check("t1.cap_idx", 32'(cap_idx), 32'd0);

    // Short window must not capture; following full window does.
    zero_counts();
    hold(4'b0010, 7'h6D, 3, "t2");
    check("t2.no_cap_short", 32'(n_cap), 32'd0);
    hold(4'b0010, 7'h7D, 3, "t2");
    check("t2.no_cap_yet", 32'(n_cap), 32'd0);
    hold(4'b0010, 7'h7D, 1, "t2");
    check("t2.cap_pulse", 32'(cap_pulse), 32'd1);
    check("t2.digit1", 32'(digits[7:4]), 32'h6);

    // Full frame.
    zero_counts();
    hold(4'b0001, 7'h3F, 5, "t3");
    hold(4'b0010, 7'h06, 5, "t3");
    hold(4'b0100, 7'h77, 5, "t3");
    hold(4'b1000, 7'h71, 5, "t3");
    check("t3.digits", 32'(digits), 32'hFA10);
    check("t3.n_cap", 32'(n_cap), 32'd4);
    check("t3.n_fd", 32'(n_fd), 32'd1);
    check("t3.fd_latency", 32'(last_fd_edge - last_cap_edge), 32'd1);
    check("t3.dig_ok_cleared", 32'(dig_ok), 32'd0);

    // Invalid pattern, then clear.
    zero_counts();
    hold(4'b0100, 7'h7E, 4, "t4");
    check("t4.cap_pulse", 32'(cap_pulse), 32'd1);
    check("t4.pat_err", 32'(pat_err), 32'd1);
    check("t4.sticky", 32'(err_sticky), 32'd1);
    check("t4.digit2_kept", 32'(digits[11:8]), 32'hA);
    check("t4.dig_ok", 32'(dig_ok), 32'b0100);
    step(4'b0100, 7'h7E, 1'b1, "t4clr");
    check("t4.sticky_clr", 32'(err_sticky), 32'd0);
    check("t4.dig_ok_clr", 32'(dig_ok), 32'd0);
    check("t4.digits_kept", 32'(digits), 32'hFA10);

    // Multi-hot select, then blanking.
    zero_counts();
    hold(4'b0011, 7'h5B, 4, "t5");
    check("t5.sel_err", 32'(sel_err), 32'd1);
    check("t5.no_cap", 32'(cap_pulse), 32'd0);
    check("t5.dig_ok", 32'(dig_ok), 32'd0);
    hold(4'b0011, 7'h5B, 2, "t5");
    check("t5.n_sel", 32'(n_sel), 32'd1);
    zero_counts();
    hold(4'b0000, 7'h3F, 20, "t5blank");
    check("t5.blank_strobes", 32'(n_cap + n_pat + n_sel + n_fd), 32'd0);

    // Reset in the middle of a stable window.
    hold(4'b0001, 7'h4F, 2, "t6");
    rst = 1'b1;
    #2;
    model_reset();
    compare_all("t6rst");
    @(posedge clk);
    #1;
    compare_all("t6rst_held");
    rst = 1'b0;
    zero_counts();
    hold(4'b0001, 7'h4F, 3, "t6");
    check("t6.no_early_cap", 32'(n_cap), 32'd0);
    hold(4'b0001, 7'h4F, 1, "t6");
    check("t6.cap_pulse", 32'(cap_pulse), 32'd1);
    check("t6.digits", 32'(digits), 32'h0003);

    // Random windows.
    for (int w = 0; w < 300; w++) begin
      a = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        6: rsel = 4'b0000;
        7: begin
          b = (a + 1 + $urandom_range(0, 2)) % 4;
          rsel = 4'(1 << a) | 4'(1 << b);
        end
        default: rsel = 4'(1 << a);
      endcase
      if ($urandom_range(0, 3) != 0) rseg = codes[$urandom_range(0, 15)];
      else                           rseg = 7'($urandom);
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        rclr = (i == 0 && $urandom_range(0, 19) == 0);
        step(rsel, rseg, rclr, "rnd");
      end
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #2;
        model_reset();
        compare_all("rnd_rst");
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive-side counterpart of the hex-to-7-segment transcoder: samples a multiplexed 7-segment display bus (segment pattern plus one-hot digit select) and recovers the hex value of each digit.
- A pattern must be stable for STABLE_CYCLES consecutive clock edges before it is decoded (glitch/ghosting filter).
- Captured nibbles go into a per-digit register bank; a frame-complete pulse fires once every digit has been captured.
- Used as a display loopback checker and as the self-check element in board-level benches.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before capture (legal range 2..255).
- NDIG, 4, number of multiplexed digits (legal range 1..8).
- IDXW, 2, width of cap_idx; must equal clog2(NDIG), minimum 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- seg_in  in  7  segment pattern {g,f,e,d,c,b,a}, active-high, bit0 = a
- dig_sel  in  NDIG  digit enable, active-high, expected one-hot or all-zero
- clr  in  1  synchronous clear of dig_ok, err_sticky and the filter
- digits  out  4*NDIG  decoded nibbles; digit i at bits [4i+3:4i]
- dig_ok  out  NDIG  digit i captured since last frame/clear
- cap_pulse  out  1  one-cycle strobe, a capture occurred
- cap_idx  out  IDXW  index of the last captured digit
- pat_err  out  1  one-cycle strobe, captured pattern not in decode table
- sel_err  out  1  one-cycle strobe, stable dig_sel was multi-hot
- err_sticky  out  1  OR of all pat_err/sel_err since reset/clr
- frame_done  out  1  one-cycle strobe, all NDIG digits captured

Behaviour:
- Reset (async, rst=1): all outputs 0, digits = 0, filter counter 0, FSM in TRACK, sample register 0.
- Sampling: each rising edge registers {dig_sel, seg_in} into smp. cnt resets to 1 when the new sample differs from smp; otherwise it increments and saturates at STABLE_CYCLES.
- FSM states: TRACK (counting) and HOLD (already captured this stable window).
- TRACK -> HOLD on the edge where cnt reaches STABLE_CYCLES and dig_sel != 0. Capture actions happen on that same edge.
  - Timing: an input applied before edge 1 and held gives cap_pulse high after edge STABLE_CYCLES.
- HOLD -> TRACK on any sample change; cnt restarts at 1. A held value is never captured twice.
- dig_sel all-zero (blanking): never captured. cnt still runs; stays in TRACK.
- Capture actions, one-hot dig_sel (bit i):
  - cap_pulse = 1, cap_idx = i, dig_ok[i] = 1.
  - Pattern valid: digits[i] = decoded nibble.
  - Pattern invalid: digits[i] unchanged, dig_ok[i] still set, pat_err = 1.
- Capture actions, multi-hot dig_sel: sel_err = 1 only. No cap_pulse, no register update. Go to HOLD.
- Decode table (seg_in hex -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - Every other code is invalid.
- Frame completion: when a capture leaves dig_ok all-ones, frame_done = 1 on the following edge, and dig_ok clears to 0 on that same edge. digits is retained.
- Recapturing an already-set digit refreshes digits[i] but does not advance the frame.
- err_sticky sets on the same edge as pat_err/sel_err and holds until clr or rst.
- clr=1: dig_ok = 0, err_sticky = 0, cnt = 0, FSM -> TRACK; strobes forced 0; digits retained.
  - clr overrides a capture or frame_done due on the same edge.
- Strobes (cap_pulse, pat_err, sel_err, frame_done) are high for exactly one cycle.
- rst asserted mid-window: everything returns to reset values immediately; no partial capture survives.

Test Plan (STABLE_CYCLES=4, NDIG=4):
- Hold dig_sel=0001, seg_in=7'h5B for 10 edges -> single cap_pulse after edge 4, cap_idx=0, digits[3:0]=2, dig_ok=0001, no further pulses.
- seg_in=7'h6D held 3 edges, then 7'h7D held 4 edges, dig_sel=0010 -> no capture at edge 3; capture after edge 7 with digits[7:4]=6.
- Cycle digits 0..3 with patterns 3F,06,77,71, each held 5 edges -> digits=16'hFA10; frame_done one cycle after the 4th cap_pulse; dig_ok returns to 0000.
- dig_sel=0100, seg_in=7'h7E held 4 edges -> cap_pulse, pat_err, err_sticky=1, digits[11:8] unchanged; then clr -> err_sticky=0, dig_ok=0.
- dig_sel=0011 held 4 edges -> sel_err pulse only, dig_ok unchanged; dig_sel=0000 held 20 edges -> no strobes.
- rst asserted at edge 2 of a stable window, released, same input held -> no capture until 4 edges after release; outputs 0 during reset.
